shift_sequencer: RTL

Sequencer and arbiter for the external 16-bit output shift register that carries 32-bit jump addresses off the FPGA. Two requesters (the single-shot extension logic and the host control path) offer 32-bit words over a valid/ready handshake. A round-robin arbiter grants one word at a time. The block then drives the shift register directly: a clear pulse, 16 serial bits, and a latch pulse for the upper half, then the same sequence for the lower half. It replaces ad-hoc counter/mux sequencing with one owner of the shift-register pins.

---
 rtl/shift_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - Round-robin arbiter and serial sequencer for the 16-bit output shift register
module shift_sequencer #(
    parameter int CLK_DIV = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        ser_data,
    output logic        ser_clk,
    output logic        shift_reg_reset,
    output logic        latch_clock,
    output logic        busy,
    output logic        done,
    output logic        grant_id
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W:0]   DIV_HALF = (DIV_W+1)'(CLK_DIV / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t           state;
    logic [31:0]      word;
    logic [15:0]      sh;
    logic             half;
    logic [3:0]       bit_cnt;
    logic             bit_last;
    logic [DIV_W-1:0] div;
    logic             last_id;
    logic             winner;
    logic             clk_high_next;

    // Winner: the lone valid requester, or on a tie the one not served last.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_id;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign req0_ready = reset_n && (state == S_IDLE) && !winner && req0_valid;
    assign req1_ready = reset_n && (state == S_IDLE) && winner && req1_valid;

    // ser_clk rises once the divider reaches the second half of the bit period.
    assign clk_high_next = (({1'b0, div} + (DIV_W+1)'(1)) >= DIV_HALF);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            word            <= '0;
            sh              <= '0;
            half            <= 1'b0;
            bit_cnt         <= '0;
            bit_last        <= 1'b0;
            div             <= '0;
            last_id         <= 1'b1;
            ser_data        <= 1'b0;
            ser_clk         <= 1'b0;
            shift_reg_reset <= 1'b0;
            latch_clock     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            grant_id        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        word            <= winner ? req1_data : req0_data;
                        grant_id        <= winner;
                        busy            <= 1'b1;
                        half            <= 1'b0;
                        shift_reg_reset <= 1'b1;
                        state           <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    shift_reg_reset <= 1'b0;
                    sh              <= half ? word[15:0] : word[31:16];
                    ser_data        <= half ? word[15] : word[31];
                    ser_clk         <= 1'b0;
                    div             <= '0;
                    bit_cnt         <= '0;
                    bit_last        <= 1'b0;
                    state           <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div == DIV_LAST) begin
                        div     <= '0;
                        ser_clk <= 1'b0;
                        if (bit_last) begin
                            ser_data    <= 1'b0;
                            latch_clock <= 1'b1;
                            state       <= S_LATCH;
                        end else begin
                            bit_cnt  <= bit_cnt + 4'd1;
                            bit_last <= (bit_cnt == 4'd14);
                            sh       <= {sh[14:0], 1'b0};
                            ser_data <= sh[14];
                        end
                    end else begin
                        div     <= div + DIV_W'(1);
                        ser_clk <= clk_high_next;
                    end
                end
                S_LATCH: begin
                    latch_clock <= 1'b0;
                    if (!half) begin
                        half            <= 1'b1;
                        shift_reg_reset <= 1'b1;
                        state           <= S_CLEAR;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    last_id <= grant_id;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
